// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths and the write-back request record.
// Imported by the write-back stage and its load-return queue.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 4;

  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // Occupancy counter width for a FIFO of the given depth (needs one extra bit for full).
  function automatic int ldq_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb_ldq.sv
// Load-return FIFO: wrapping read/write pointers plus an occupancy count,
// with a per-entry valid/dest view so the top can build the busy mask.
module wb_ldq
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [REG_AW-1:0]         push_dest,
  input  logic [DATA_W-1:0]         push_data,
  input  logic                      pop,
  output logic                      full,
  output logic                      empty,
  output logic [ldq_cnt_w(DEPTH)-1:0] count,
  output logic [REG_AW-1:0]         head_dest,
  output logic [DATA_W-1:0]         head_data,
  output logic [DEPTH-1:0]          entry_valid,
  output logic [DEPTH*REG_AW-1:0]   entry_dest
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = ldq_cnt_w(DEPTH);

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [REG_AW-1:0] dest_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count_reg <= count_next;
    end
  end

  // Storage needs no reset: entries are only observed through entry_valid / count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      data_mem[wr_ptr] <= push_data;
      dest_mem[wr_ptr] <= push_dest;
    end
  end

  assign head_dest = dest_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PTR_W-1:0] offset;
      // Entry is live when its distance from the head is below the occupancy.
      assign offset          = PTR_W'(gi) - rd_ptr;
      assign entry_valid[gi] = ({1'b0, offset} < count_reg);
      assign entry_dest[gi*REG_AW +: REG_AW] = dest_mem[gi];
    end
  endgenerate

endmodule

// File: rtl/wb_writeback.sv
// Write-back stage: arbitrates queued load returns against in-order ALU
// results onto the single registered register-file write port.
module wb_writeback
  import cpu_pkg::*;
#(
  parameter int DATA_W     = cpu_pkg::DATA_W,
  parameter int REG_AW     = cpu_pkg::REG_AW,
  parameter int LDQ_DEPTH  = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            alu_valid,
  output logic                            alu_ready,
  input  logic                            alu_wb,
  input  logic [REG_AW-1:0]               alu_dest,
  input  logic [DATA_W-1:0]               alu_data,
  input  logic                            ld_valid,
  output logic                            ld_ready,
  input  logic [REG_AW-1:0]               ld_dest,
  input  logic [DATA_W-1:0]               ld_data,
  output logic                            regwrite_en,
  output logic [REG_AW-1:0]               regwrite_dest,
  output logic [DATA_W-1:0]               regwrite_data,
  output logic [2**REG_AW-1:0]            busy_mask,
  output logic [ldq_cnt_w(LDQ_DEPTH)-1:0] ldq_count
);

  localparam int NREG = 2**REG_AW;
  localparam int SW   = $clog2(STARVE_MAX + 1);

  logic                        ldq_full;
  logic                        ldq_empty;
  logic [REG_AW-1:0]           head_dest;
  logic [DATA_W-1:0]           head_data;
  logic [LDQ_DEPTH-1:0]        entry_valid;
  logic [LDQ_DEPTH*REG_AW-1:0] entry_dest;

  logic          grant_ld;
  logic          alu_xfer;
  logic [SW-1:0] starve_cnt;
  logic [SW-1:0] starve_next;

  wb_ldq #(
    .DEPTH  (LDQ_DEPTH),
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_ldq (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (ld_valid),
    .push_dest   (ld_dest),
    .push_data   (ld_data),
    .pop         (grant_ld),
    .full        (ldq_full),
    .empty       (ldq_empty),
    .count       (ldq_count),
    .head_dest   (head_dest),
    .head_data   (head_data),
    .entry_valid (entry_valid),
    .entry_dest  (entry_dest)
  );

  // Loads win unless the ALU has already been passed over STARVE_MAX times.
  assign grant_ld  = !ldq_empty && (starve_cnt < SW'(STARVE_MAX));
  assign alu_ready = !grant_ld;
  assign ld_ready  = !ldq_full;
  assign alu_xfer  = alu_valid && alu_ready;

  always_comb begin
    starve_next = starve_cnt;
    if (alu_xfer || !alu_valid) begin
      starve_next = '0;
    end else if (grant_ld && (starve_cnt < SW'(STARVE_MAX))) begin
      starve_next = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt    <= '0;
      regwrite_en   <= 1'b0;
      regwrite_dest <= '0;
      regwrite_data <= '0;
    end else begin
      starve_cnt <= starve_next;
      if (grant_ld) begin
        regwrite_en   <= 1'b1;
        regwrite_dest <= head_dest;
        regwrite_data <= head_data;
      end else if (alu_xfer && alu_wb) begin
        regwrite_en   <= 1'b1;
        regwrite_dest <= alu_dest;
        regwrite_data <= alu_data;
      end else begin
        regwrite_en   <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      logic hit;
      always_comb begin
        hit = 1'b0;
        for (int e = 0; e < LDQ_DEPTH; e++) begin
          if (entry_valid[e] && (entry_dest[e*REG_AW +: REG_AW] == REG_AW'(gi))) hit = 1'b1;
        end
      end
      assign busy_mask[gi] = hit;
    end
  endgenerate

endmodule

// File: tb/tb_wb_writeback.sv
// Directed + random checks of wb_writeback against a queue-based model of the
// load FIFO, the starvation rule and the registered write port.
module tb_wb_writeback;

  localparam int DEPTH = 4;
  localparam int SMAX  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_wb, ld_valid;
  logic        alu_ready, ld_ready;
  logic [3:0]  alu_dest, ld_dest;
  logic [31:0] alu_data, ld_data;
  logic        regwrite_en;
  logic [3:0]  regwrite_dest;
  logic [31:0] regwrite_data;
  logic [15:0] busy_mask;
  logic [2:0]  ldq_count;

  wb_writeback dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_wb        (alu_wb),
    .alu_dest      (alu_dest),
    .alu_data      (alu_data),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .ld_dest       (ld_dest),
    .ld_data       (ld_data),
    .regwrite_en   (regwrite_en),
    .regwrite_dest (regwrite_dest),
    .regwrite_data (regwrite_data),
    .busy_mask     (busy_mask),
    .ldq_count     (ldq_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  dest;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  int          starve;
  logic        exp_en;
  logic [3:0]  exp_dest;
  logic [31:0] exp_data;
  logic        last_alu_xfer, last_push;
  logic [31:0] wr_log[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    starve   = 0;
    exp_en   = 1'b0;
    exp_dest = '0;
    exp_data = '0;
  endtask

  // One clock: check ready/occupancy/busy before the edge, advance the model, check the write port after.
  task automatic step();
    logic        e_ldr, e_alur, g;
    logic [15:0] bm;
    ent_t        head;
    @(negedge clk);
    e_ldr  = (q.size() < DEPTH);
    e_alur = (q.size() == 0) || (starve >= SMAX);
    g      = (q.size() != 0) && (starve < SMAX);
    bm     = '0;
    foreach (q[i]) bm[q[i].dest] = 1'b1;
    chk("ld_ready",  {31'b0, ld_ready},  {31'b0, e_ldr});
    chk("alu_ready", {31'b0, alu_ready}, {31'b0, e_alur});
    chk("ldq_count", {29'b0, ldq_count}, q.size());
    chk("busy_mask", {16'b0, busy_mask}, {16'b0, bm});
    last_alu_xfer = alu_valid && e_alur;
    last_push     = ld_valid && e_ldr;
    if (g) begin
      head     = q.pop_front();
      exp_en   = 1'b1;
      exp_dest = head.dest;
      exp_data = head.data;
    end else if (last_alu_xfer && alu_wb) begin
      exp_en   = 1'b1;
      exp_dest = alu_dest;
      exp_data = alu_data;
    end else begin
      exp_en   = 1'b0;
    end
    if (last_alu_xfer || !alu_valid) starve = 0;
    else if (g && starve < SMAX) starve++;
    if (last_push) q.push_back('{ld_dest, ld_data});
    @(posedge clk);
    #1;
    chk("regwrite_en",   {31'b0, regwrite_en},   {31'b0, exp_en});
    chk("regwrite_dest", {28'b0, regwrite_dest}, {28'b0, exp_dest});
    chk("regwrite_data", regwrite_data, exp_data);
    if (regwrite_en === 1'b1) wr_log.push_back(regwrite_data);
    $display("cyc t=%0t alu v/r=%0b/%0b ld v/r=%0b/%0b wr en=%0b d=%0d data=%0h cnt=%0d busy=%04h",
             $time, alu_valid, alu_ready, ld_valid, ld_ready, regwrite_en, regwrite_dest,
             regwrite_data, ldq_count, busy_mask);
  endtask

  initial begin
    logic [3:0] fill_dests [4];
    int         fi;
    int         guard;
    fill_dests[0] = 4'd1; fill_dests[1] = 4'd2; fill_dests[2] = 4'd3; fill_dests[3] = 4'd3;

    rst_n = 1'b0;
    alu_valid = 0; alu_wb = 0; alu_dest = 0; alu_data = 0;
    ld_valid = 0; ld_dest = 0; ld_data = 0;
    model_reset();
    #1;
    chk("rst_en",    {31'b0, regwrite_en}, 32'd0);
    chk("rst_count", {29'b0, ldq_count},   32'd0);
    chk("rst_busy",  {16'b0, busy_mask},   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU only, with and without a register write
    alu_valid = 1; alu_wb = 1; alu_dest = 4'd5; alu_data = 32'h0000_00AA;
    step();
    chk("alu_wr_data", regwrite_data, 32'h0000_00AA);
    alu_valid = 0;
    step();
    alu_valid = 1; alu_wb = 0; alu_dest = 4'd6; alu_data = 32'h0000_00BB;
    step();
    chk("alu_nowb_dest", {28'b0, regwrite_dest}, 32'd5);
    alu_valid = 0;
    step();

    // Fill the FIFO with dests 1,2,3,3 while the ALU competes for the port
    alu_valid = 1; alu_wb = 1; alu_dest = 4'd9; alu_data = 32'h1234_0000;
    fi = 0; guard = 0;
    while (q.size() < DEPTH && guard < 60) begin
      ld_valid = 1; ld_dest = fill_dests[fi % 4]; ld_data = 32'hD000_0000 | fi;
      step();
      if (last_push) fi++;
      if (last_alu_xfer) alu_data = alu_data + 1;
      guard++;
    end
    chk("fill_reached", q.size(), DEPTH);
    // Full + pop + ld_valid in one cycle: nothing enters, ready returns next cycle
    ld_valid = 1; ld_dest = 4'd12; ld_data = 32'hFFFF_0001;
    step();
    ld_valid = 0; alu_valid = 0;
    repeat (3) step();
    repeat (2) step();

    // Starvation: loads streaming in, ALU held valid
    alu_valid = 1; alu_wb = 1; alu_dest = 4'd4; alu_data = 32'hA100_0000;
    for (int i = 0; i < 16; i++) begin
      ld_valid = 1; ld_dest = 4'(i); ld_data = 32'hB000_0000 + i;
      step();
      if (last_alu_xfer) alu_data = alu_data + 1;
    end
    ld_valid = 0; alu_valid = 0;
    repeat (6) step();

    // Wrap: ten loads to r7, data 1..10, in order
    wr_log.delete();
    for (int i = 1; i <= 10; i++) begin
      ld_valid = 1; ld_dest = 4'd7; ld_data = i;
      step();
    end
    ld_valid = 0;
    repeat (4) step();
    chk("wrap_count", wr_log.size(), 32'd10);
    for (int i = 0; i < 10 && i < wr_log.size(); i++) chk("wrap_seq", wr_log[i], i + 1);

    // Random traffic, honouring hold-while-stalled
    alu_valid = 0; ld_valid = 0;
    for (int i = 0; i < 400; i++) begin
      if (!alu_valid || last_alu_xfer) begin
        alu_valid = ($urandom_range(0, 3) != 0);
        alu_wb    = $urandom_range(0, 1);
        alu_dest  = 4'($urandom);
        alu_data  = $urandom;
      end
      if (!ld_valid || last_push) begin
        ld_valid = ($urandom_range(0, 1) != 0);
        ld_dest  = 4'($urandom);
        ld_data  = $urandom;
      end
      step();
    end

    // Reset mid-stream with three loads queued
    guard = 0;
    alu_valid = 1; alu_wb = 1;
    while (q.size() != 3 && guard < 200) begin
      ld_valid = 1; ld_dest = 4'($urandom); ld_data = $urandom;
      step();
      guard++;
    end
    chk("pre_rst_q3", q.size(), 32'd3);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_en",    {31'b0, regwrite_en}, 32'd0);
    chk("mid_rst_count", {29'b0, ldq_count},   32'd0);
    chk("mid_rst_busy",  {16'b0, busy_mask},   32'd0);
    alu_valid = 0; ld_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
